inst_fetch_buf: RTL and testbench

Instruction fetch buffer sitting between the PC stage / synchronous instruction ROM and the decode stage. It tracks the one outstanding ROM request, pairs each returned instruction word with its fetch address, and queues the pairs in a small FIFO presented to decode with a valid/ready handshake. It raises a credit-based stall request back to the PC stage so no fetched instruction is ever dropped, and supports a single-cycle flush for branch redirects.

---
 rtl/inst_fetch_buf_pkg.sv | 22 ++
 rtl/inst_fetch_buf_if.sv | 40 ++++
 rtl/inst_fetch_buf_fetch_fifo.sv | 78 +++++++
 rtl/inst_fetch_buf.sv | 78 +++++++
 tb/tb_inst_fetch_buf.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared bus widths, constants and types for the instruction fetch buffer.
// The {pc, inst} pair is the unit stored in the fetch FIFO.
package inst_fetch_buf_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord   = 32'h0000_0000;
    localparam logic [InstBus-1:0]     NopInst    = 32'h0000_0000;
    localparam logic                   RstnEnable = 1'b0;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } pend_state_e;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Fetch-side (PC stage / ROM) and decode-side handshake signals of the fetch buffer.
// The buffer takes the slave modport; the PC/decode environment takes master.
interface inst_fetch_buf_if;
    import inst_fetch_buf_pkg::*;

    logic [InstAddrBus-1:0] pc_i;
    logic                   ce_i;
    logic [InstBus-1:0]     inst_i;
    logic                   flush_i;
    logic                   id_ready_i;
    logic                   id_valid_o;
    logic [InstAddrBus-1:0] id_pc_o;
    logic [InstBus-1:0]     id_inst_o;
    logic                   stall_req_o;

    modport slave (
        input  pc_i,
        input  ce_i,
        input  inst_i,
        input  flush_i,
        input  id_ready_i,
        output id_valid_o,
        output id_pc_o,
        output id_inst_o,
        output stall_req_o
    );

    modport master (
        output pc_i,
        output ce_i,
        output inst_i,
        output flush_i,
        output id_ready_i,
        input  id_valid_o,
        input  id_pc_o,
        input  id_inst_o,
        input  stall_req_o
    );

endinterface

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// Show-ahead FIFO of {pc, inst} pairs with single-cycle flush.
// Caller guarantees push never lands on a full FIFO; head reads as zero when empty.
module fetch_fifo
    import inst_fetch_buf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;
    logic [DEPTH-1:0] wr_sel;

    fetch_entry_t mem [DEPTH];

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = (wr_ptr_q == PW'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(do_push);
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && wr_sel[i]) begin
                mem[i] <= push_data_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch buffer: tracks the one outstanding ROM request, queues returned {pc, inst}
// pairs for decode and raises a credit-based stall so no fetched word is dropped.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_buf_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] OCC_LIMIT = DEPTH[CW:0];

    pend_state_e            pend_state_q, pend_state_d;
    logic [InstAddrBus-1:0] pend_pc_q, pend_pc_d;
    logic                   pend_valid;
    logic                   req_accept;
    logic                   stall;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            occupancy;
    fetch_entry_t           fifo_head;
    fetch_entry_t           push_entry;

    assign pend_valid = (pend_state_q == PEND_WAIT);

    // Credit check counts the in-flight word as already occupying a slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pend_valid};
    assign stall     = (occupancy >= OCC_LIMIT);

    assign req_accept = bus.ce_i && !stall && !bus.flush_i;

    always_comb begin
        pend_state_d = PEND_IDLE;
        pend_pc_d    = pend_pc_q;
        if (req_accept) begin
            pend_state_d = PEND_WAIT;
            pend_pc_d    = bus.pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            pend_state_q <= PEND_IDLE;
            pend_pc_q    <= ZeroWord;
        end else begin
            pend_state_q <= pend_state_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign fifo_push       = pend_valid && !bus.flush_i;
    assign fifo_pop        = (fifo_count != '0) && bus.id_ready_i;
    assign push_entry.pc   = pend_pc_q;
    assign push_entry.inst = bus.inst_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (bus.flush_i),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign bus.id_valid_o  = (fifo_count != '0);
    assign bus.id_pc_o     = bus.id_valid_o ? fifo_head.pc   : ZeroWord;
    assign bus.id_inst_o   = bus.id_valid_o ? fifo_head.inst : NopInst;
    assign bus.stall_req_o = stall;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Randomised bench for inst_fetch_buf: a queue-based reference model of the fetch
// buffer feeds a scoreboard that a separate monitor drains on every decode handshake.
module tb_inst_fetch_buf;
    import inst_fetch_buf_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_buf_if bus ();

    inst_fetch_buf #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pair_t       exp_q[$];
    pair_t       head_e;
    bit          model_pend;
    logic [31:0] model_pend_pc;
    bit          exp_stall;
    bit          last_ce;
    logic [31:0] last_pc;
    logic [31:0] next_pc;
    logic [31:0] rom [1024];
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model state after the last edge and
    // retires the expected head whenever decode takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            exp_stall = (exp_q.size() + int'(model_pend)) >= DEPTH;
            check("stall_req", 32'(bus.stall_req_o), 32'(exp_stall));
            check("id_valid", 32'(bus.id_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                check("empty_pc", bus.id_pc_o, 32'h0);
                check("empty_inst", bus.id_inst_o, 32'h0);
            end else if (bus.id_ready_i) begin
                head_e = exp_q.pop_front();
                check("head_pc", bus.id_pc_o, head_e.pc);
                check("head_inst", bus.id_inst_o, head_e.inst);
                $display("pop pc=%h inst=%h", bus.id_pc_o, bus.id_inst_o);
            end
        end
    end

    // One clock of stimulus, then the model's view of the coming edge.
    task automatic cycle(input int p_ce, input int p_ready, input int p_flush);
        bit accept;
        @(negedge clk);
        bus.pc_i       = next_pc;
        bus.ce_i       = ($urandom_range(99) < p_ce);
        bus.id_ready_i = ($urandom_range(99) < p_ready);
        bus.flush_i    = ($urandom_range(99) < p_flush);
        bus.inst_i     = last_ce ? rom[last_pc[11:2]] : $urandom();
        #3;
        accept = bus.ce_i && !exp_stall && !bus.flush_i;
        if (bus.flush_i) begin
            exp_q.delete();
            model_pend = 1'b0;
            next_pc    = 32'h100 + 32'($urandom_range(0, 63)) * 4;
        end else begin
            if (model_pend) begin
                exp_q.push_back('{model_pend_pc, bus.inst_i});
            end
            model_pend = accept;
            if (accept) begin
                model_pend_pc = bus.pc_i;
                next_pc       = (bus.pc_i + 32'd4) & 32'h0000_0FFC;
            end
        end
        last_ce = bus.ce_i;
        last_pc = bus.pc_i;
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_pend = 1'b0;
        last_ce    = 1'b0;
        next_pc    = 32'h0;
        bus.pc_i   = 32'h0;
        bus.ce_i   = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset_mid_cycle();
        @(negedge clk);
        #4;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.id_valid_o), 32'h0);
        check("rst_stall", 32'(bus.stall_req_o), 32'h0);
        check("rst_pc", bus.id_pc_o, 32'h0);
        check("rst_inst", bus.id_inst_o, 32'h0);
        model_clear();
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = $urandom();
        end
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;
        bus.id_ready_i = 1'b0;
        bus.inst_i     = 32'h0;
        model_pend_pc  = 32'h0;
        last_pc        = 32'h0;
        exp_stall      = 1'b0;
        model_clear();

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        repeat (6)  cycle(100, 100, 0);   // stream from reset
        repeat (12) cycle(100, 0, 0);     // backpressure until stalled
        repeat (10) cycle(100, 100, 0);   // full with simultaneous push/pop
        repeat (3)  cycle(100, 0, 0);
        cycle(100, 100, 100);             // flush with request in flight
        repeat (8)  cycle(100, 100, 0);
        repeat (8)  cycle(100, 0, 0);
        async_reset_mid_cycle();
        repeat (6)  cycle(100, 100, 0);
        repeat (3000) cycle(70, 60, 3);   // random mix incl. pointer wrap
        repeat (12) cycle(0, 100, 0);     // drain

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
